// File: rtl/o_pkg.sv
// Shared constants for the o_dec unary screening stage.
// Holds the reset values of the output stage and the default parameter values.
// Optional build macro used by the block: O_DEC_REJECT_FWD_EN.
package o_pkg;

    // Default parameter values of the stage.
    localparam int DEF_W      = 16;
    localparam int DEF_CMP_EN = 1;
    localparam int DEF_CW     = 8;

    // Reset state of the output entry and of the buffer occupancy flags.
    localparam logic RST_VLD = 1'b0;
    localparam logic RST_CMP = 1'b0;
    localparam logic RST_ERR = 1'b0;

endpackage

// File: rtl/o_dec_adm.sv
// Purpose : combinational admission check of a W-bit thermometer vector plus popcount.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; evaluated on every input, the caller qualifies it with the handshake.
// Ports   : x_i vector in; admit_o = vector is a legal unary form; k_o = unary count;
//           cmp_o = vector was in complemented form (only meaningful with admit_o).
module o_dec_adm
    import o_pkg::*;
#(
    parameter  int W      = DEF_W,
    parameter  int CMP_EN = DEF_CMP_EN,
    localparam int KW     = $clog2(W)
) (
    input  logic [W-1:0]  x_i,
    output logic          admit_o,
    output logic [KW-1:0] k_o,
    output logic          cmp_o
);

    logic [W-1:0] src;
    logic         is_mask;

    always_comb begin
        // An MSB of 1 can only ever be legal as the complemented form: the plain
        // form tops out at 2^(W-1)-1, so all-ones falls to the complement side.
        cmp_o   = x_i[W-1];
        src     = cmp_o ? ~x_i : x_i;
        // src is of the form 2^k-1 exactly when adding one clears every set bit.
        is_mask = ((src & (src + W'(1))) == '0);
        admit_o = is_mask && (!cmp_o || (CMP_EN != 0));

        // Admitted sources have at most W-1 ones, which always fits in KW bits.
        k_o = '0;
        for (int i = 0; i < W; i++) begin
            k_o = k_o + KW'(src[i]);
        end
    end

endmodule

// File: rtl/o_dec.sv
// Purpose : registered screening stage for thermometer vectors, emits count + complement flag.
// Latency : 1 cycle from input transfer to o_valid; full throughput via 2-entry skid buffer.
// Backpr. : o_ready = !skid_valid (registered); stalled output holds o_k/o_is_compliment.
// Ports   : clk/rst_n (sync, active-low); i_valid/i_x/o_ready input side;
//           o_valid/o_k/o_is_compliment/i_ready output side; o_reject_cnt saturating counter.
// Macro   : O_DEC_REJECT_FWD_EN forwards rejected vectors as k=0/cmp=0 with o_err=1.
module o_dec
    import o_pkg::*;
#(
    parameter  int W                     = DEF_W,
    parameter  int P_ADMIT_COMPLIMENT_EN = DEF_CMP_EN,
    parameter  int CW                    = DEF_CW,
    localparam int KW                    = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [W-1:0]  i_x,
    output logic          o_ready,
    output logic          o_valid,
    output logic [KW-1:0] o_k,
    output logic          o_is_compliment,
    input  logic          i_ready,
`ifdef O_DEC_REJECT_FWD_EN
    output logic          o_err,
`endif
    output logic [CW-1:0] o_reject_cnt
);

    typedef struct packed {
        logic [KW-1:0] k;
        logic          cmp;
`ifdef O_DEC_REJECT_FWD_EN
        logic          err;
`endif
    } entry_t;

    entry_t        main_q, main_d;
    entry_t        skid_q, skid_d;
    entry_t        in_ent;
    logic          main_vld_q, main_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic [CW-1:0] rej_q, rej_d;

    logic          adm_ok;
    logic [KW-1:0] adm_k;
    logic          adm_cmp;
    logic          in_xfer;
    logic          push;
    logic          stall;

    o_dec_adm #(
        .W      (W),
        .CMP_EN (P_ADMIT_COMPLIMENT_EN)
    ) u_adm (
        .x_i     (i_x),
        .admit_o (adm_ok),
        .k_o     (adm_k),
        .cmp_o   (adm_cmp)
    );

    assign in_xfer = i_valid & o_ready;
    // Output is blocked only when the main register holds an entry nobody takes.
    assign stall   = main_vld_q & ~i_ready;

`ifdef O_DEC_REJECT_FWD_EN
    assign push = in_xfer;
`else
    assign push = in_xfer & adm_ok;
`endif

    always_comb begin
        in_ent     = '0;
        in_ent.k   = adm_ok ? adm_k : '0;
        in_ent.cmp = adm_ok & adm_cmp;
`ifdef O_DEC_REJECT_FWD_EN
        in_ent.err = ~adm_ok;
`endif
    end

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        rej_d      = rej_q;

        if (stall) begin
            // Main is stuck; o_ready guarantees the skid slot is free for a push.
            if (push) begin
                skid_d     = in_ent;
                skid_vld_d = 1'b1;
            end
        end else if (skid_vld_q) begin
            // Main is draining or empty: refill it from skid first to keep order.
            // o_ready is low in this state, so no new entry can arrive here.
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
        end else begin
            // Skid empty: a new entry replaces main directly, otherwise main empties.
            main_vld_d = push;
            if (push) begin
                main_d = in_ent;
            end
        end

        if (in_xfer && !adm_ok && (rej_q != '1)) begin
            rej_d = rej_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_q.cmp <= RST_CMP;
`ifdef O_DEC_REJECT_FWD_EN
            main_q.err <= RST_ERR;
`endif
            skid_q     <= '0;
            main_vld_q <= RST_VLD;
            skid_vld_q <= RST_VLD;
            rej_q      <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rej_q      <= rej_d;
        end
    end

    assign o_ready         = ~skid_vld_q;
    assign o_valid         = main_vld_q;
    assign o_k             = main_q.k;
    assign o_is_compliment = main_q.cmp;
    assign o_reject_cnt    = rej_q;
`ifdef O_DEC_REJECT_FWD_EN
    assign o_err           = main_q.err;
`endif

endmodule

// File: tb/tb_o_dec.sv
// Bench for o_dec: scoreboard of expected output entries, pushed at input transfer
// and popped when the DUT hands an entry downstream; extra DUTs cover the
// complement-disabled and narrow-counter configurations.
module tb_o_dec;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_x;
    logic       i_ready;
    logic       v_main, v_nc, v_sat;

    // main DUT: W=8, complement enabled, CW=8
    logic       m_ready, m_valid, m_cmp;
    logic [2:0] m_k;
    logic [7:0] m_rej;
    // complement disabled DUT
    logic       nc_ready, nc_valid, nc_cmp;
    logic [2:0] nc_k;
    logic [7:0] nc_rej;
    // saturation DUT: CW=4
    logic       s_ready, s_valid, s_cmp;
    logic [2:0] s_k;
    logic [3:0] s_rej;
`ifdef O_DEC_REJECT_FWD_EN
    logic       m_err, nc_err, s_err;
`endif

    always #5 clk = ~clk;

    o_dec #(.W(8), .P_ADMIT_COMPLIMENT_EN(1), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(v_main), .i_x(i_x), .o_ready(m_ready),
        .o_valid(m_valid), .o_k(m_k), .o_is_compliment(m_cmp), .i_ready(i_ready),
`ifdef O_DEC_REJECT_FWD_EN
        .o_err(m_err),
`endif
        .o_reject_cnt(m_rej)
    );

    o_dec #(.W(8), .P_ADMIT_COMPLIMENT_EN(0), .CW(8)) dut_nc (
        .clk(clk), .rst_n(rst_n), .i_valid(v_nc), .i_x(i_x), .o_ready(nc_ready),
        .o_valid(nc_valid), .o_k(nc_k), .o_is_compliment(nc_cmp), .i_ready(i_ready),
`ifdef O_DEC_REJECT_FWD_EN
        .o_err(nc_err),
`endif
        .o_reject_cnt(nc_rej)
    );

    o_dec #(.W(8), .P_ADMIT_COMPLIMENT_EN(1), .CW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_valid(v_sat), .i_x(i_x), .o_ready(s_ready),
        .o_valid(s_valid), .o_k(s_k), .o_is_compliment(s_cmp), .i_ready(i_ready),
`ifdef O_DEC_REJECT_FWD_EN
        .o_err(s_err),
`endif
        .o_reject_cnt(s_rej)
    );

    typedef struct {
        int k;
        int cmp;
        int err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_rej = 0;
    int   m_outs  = 0;
    int   nc_outs = 0;
    int   base;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: enumerate every legal unary / complemented-unary pattern.
    function automatic void model(input logic [7:0] x, input bit cmp_en,
                                  output bit ok, output int k, output int cmp);
        logic [7:0] m;
        ok = 1'b0; k = 0; cmp = 0;
        for (int j = 0; j < 8; j++) begin
            m = 8'((1 << j) - 1);
            if (x == m) begin
                ok = 1'b1; k = j; cmp = 0;
            end else if (cmp_en && x == ~m) begin
                ok = 1'b1; k = j; cmp = 1;
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [7:0] x);
        int   n;
        bit   ok;
        int   k, c;
        exp_t t;
        n      = 0;
        v_main = 1'b1;
        i_x    = x;
        while (!m_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            model(x, 1'b1, ok, k, c);
            if (ok) begin
                t.k = k; t.cmp = c; t.err = 0;
                sb.push_back(t);
            end else begin
`ifdef O_DEC_REJECT_FWD_EN
                t.k = 0; t.cmp = 0; t.err = 1;
                sb.push_back(t);
`endif
                if (exp_rej < 255) exp_rej++;
            end
        end
        @(negedge clk);
        v_main = 1'b0;
    endtask

    // Output monitor: sampled after the negedge, when inputs for the next edge are settled.
    always @(negedge clk) begin
        #1;
        if (rst_n === 1'b1 && m_valid === 1'b1 && i_ready === 1'b1) begin
            m_outs++;
            if (sb.size() == 0) begin
                check("extra_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_k", int'(m_k), e.k);
                check("out_cmp", int'(m_cmp), e.cmp);
`ifdef O_DEC_REJECT_FWD_EN
                check("out_err", int'(m_err), e.err);
`endif
            end
        end
        if (rst_n === 1'b1 && nc_valid === 1'b1 && i_ready === 1'b1) nc_outs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; i_x = '0; i_ready = 1'b1;
        v_main = 1'b0; v_nc = 1'b0; v_sat = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(m_valid), 0);
        check("rst_ready", int'(m_ready), 1);
        check("rst_k", int'(m_k), 0);
        check("rst_cmp", int'(m_cmp), 0);
        check("rst_rej", int'(m_rej), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single vector, one-cycle latency
        send(8'h1F);
        check("lat_valid", int'(m_valid), 1);
        check("rej_zero", int'(m_rej), 0);

        // complement forms
        send(8'hE0);
        send(8'hFF);

        // reject then zero
        send(8'h29);
        send(8'h00);
        repeat (2) @(negedge clk);
        check("rej_cnt", int'(m_rej), exp_rej);
        check("rej_one", int'(m_rej), 1);
        check("drained_a", sb.size(), 0);

        // complement disabled: E0 must be rejected
        i_x = 8'hE0; v_nc = 1'b1;
        @(negedge clk);
        v_nc = 1'b0;
        repeat (3) @(negedge clk);
        check("nc_rej", int'(nc_rej), 1);
`ifdef O_DEC_REJECT_FWD_EN
        check("nc_outs", nc_outs, 1);
`else
        check("nc_outs", nc_outs, 0);
`endif

        // backpressure
        i_ready = 1'b0;
        send(8'h01);
        send(8'h03);
        check("bp_rdy_low", int'(m_ready), 0);
        v_main = 1'b1; i_x = 8'h07;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_rdy", int'(m_ready), 0);
            check("bp_hold_k", int'(m_k), 1);
            check("bp_hold_vld", int'(m_valid), 1);
        end
        i_ready = 1'b1;
        send(8'h07);
        repeat (3) @(negedge clk);
        check("bp_drained", sb.size(), 0);

        // reset while the buffer is full
        i_ready = 1'b0;
        send(8'h01);
        send(8'h03);
        check("mr_full", int'(m_ready), 0);
        rst_n = 1'b0;
        sb.delete();
        exp_rej = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mr_valid", int'(m_valid), 0);
        check("mr_ready", int'(m_ready), 1);
        check("mr_rej", int'(m_rej), 0);
        base = m_outs;
        i_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("mr_no_stale", m_outs - base, 0);
        send(8'h07);
        repeat (2) @(negedge clk);
        check("mr_drained", sb.size(), 0);
        check("mr_outs", m_outs - base, 1);

        // saturation on the 4-bit counter
        i_x = 8'h29; v_sat = 1'b1;
        repeat (10) @(negedge clk);
        check("sat_mid", int'(s_rej), 10);
        repeat (10) @(negedge clk);
        check("sat_15", int'(s_rej), 15);
        repeat (5) @(negedge clk);
        v_sat = 1'b0;
        @(negedge clk);
        check("sat_hold", int'(s_rej), 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
